fb_plot_reader: RTL and testbench
=================================

Name: fb_plot_reader

Overview:
- Sink end of the vga_x/vga_y/vga_colour/vga_plot pixel-writer interface that the drawing blocks (line, circle, fill) drive.
- Holds a 160x120x3-bit framebuffer in on-chip RAM.
- Accepts plot writes from any drawer and can clear the buffer.
- Streams the buffer back in raster order over a valid/ready port, for the VGA adapter or for bench scoreboards.

Parameters:
- FB_W, 160, framebuffer width in pixels (x range 0..FB_W-1)
- FB_H, 120, framebuffer height in pixels (y range 0..FB_H-1)
- CLEAR_COLOUR, 3'b000, colour written to every pixel by a clear operation

Ports:
- clk  input  1  system clock, all logic on its rising edge
- rst_n  input  1  asynchronous active-low reset
- vga_x  input  8  plot x coordinate
- vga_y  input  7  plot y coordinate
- vga_colour  input  3  plot colour
- vga_plot  input  1  write strobe, one pixel per cycle while high
- start_clear  input  1  request buffer clear
- start_dump  input  1  request raster read-out
- done  output  1  operation complete, held until both starts are low
- out_x  output  8  x of presented pixel
- out_y  output  7  y of presented pixel
- out_colour  output  3  colour of presented pixel
- out_valid  output  1  out_* hold a pixel
- out_ready  input  1  consumer accepts pixel when high with out_valid

Behaviour:
- Clock and reset: one clock, clk; reset rst_n is asynchronous, active-low.
- Reset values: done=0, out_valid=0, out_x=0, out_y=0, out_colour=0, state IDLE. RAM contents are not affected by reset.
- Address: addr = y*FB_W + x, 15 bits, computed without truncation.
- Plot writes:
  - Accepted in IDLE, DUMP and DONE.
  - Dropped silently in CLEAR.
  - Dropped when x>=FB_W or y>=FB_H.
  - Write lands one edge after vga_plot is sampled.
- RAM: synchronous single-clock, 1-cycle read latency, read-during-write returns old data.
- States: IDLE, CLEAR, DUMP, DONE.
- IDLE:
  - start_clear sampled high -> CLEAR.
  - Otherwise start_dump high -> DUMP.
  - Both high -> CLEAR wins.
- CLEAR:
  - Writes CLEAR_COLOUR to addr 0..FB_W*FB_H-1, one per cycle (19200 cycles).
  - After the last write -> DONE.
- DUMP:
  - Read address counter starts at 0.
  - First out_valid rises 2 edges after the edge that sampled start_dump.
  - out_* stay stable while out_valid=1 and out_ready=0.
  - A transfer occurs on any edge with out_valid and out_ready both high.
  - With out_ready held high, sustained throughput is 1 pixel/cycle. Prefetch stage plus output register, no bubbles.
  - out_x/out_y increment x first; x wraps at FB_W-1 to 0 and y increments.
  - After the transfer of (FB_W-1, FB_H-1): out_valid=0, state DONE.
  - A plot to an address already fetched does not alter the presented pixel.
- DONE:
  - done=1.
  - When start_clear=0 and start_dump=0 -> IDLE, with done=0 on the next edge.
  - A start held high never retriggers.
- Reset mid-operation: immediate return to IDLE with outputs at reset values. A partial clear leaves the RAM partially cleared.
- out_ready high while out_valid=0: no effect.

Optional Feature:
- Macro: FB_NONZERO_ONLY_EN.
- Defined: DUMP skips pixels whose colour is 0. Those pixels are never presented, and the read counter advances past them without a transfer. An all-zero buffer reaches DONE with no out_valid pulse. done asserts after the scan of the last address completes.
- Undefined: every pixel is presented, exactly FB_W*FB_H transfers.

Decomposition:
- Shared package fb_pkg:
  - FB_W/FB_H defaults
  - FB_PIXELS = FB_W*FB_H
  - addr width localparam
  - colour typedef (3-bit)
  - state enum typedef
- One sub-module, fb_ram: inferred 1R1W synchronous RAM, FB_PIXELS x 3, old-data read-during-write.
- fb_plot_reader holds the FSM, counters, prefetch and output registers.

Test Plan:
- Reset, clear: start_clear 1 cycle -> done rises after 19200+ cycles.
- Clear then dump, out_ready=1: exactly 19200 transfers, all colour 0. First is (0,0), last is (159,119), no gaps after the first valid.
- Plot (5,3,colour 3'b010) and (159,119,3'b111), then dump: colour 010 at transfer 485, colour 111 at transfer 19199, all others 0.
- Plot (160,0,7) and (0,120,7), then dump: all pixels 0 (out-of-range dropped).
- Backpressure: dump with out_ready toggled pseudo-randomly -> out_* stable while stalled, sequence identical to the unstalled run, 19200 transfers.
- Reset asserted mid-dump at transfer 1000: out_valid=0 and done=0 immediately; a fresh dump restarts at (0,0).
- FB_NONZERO_ONLY_EN defined, with two plots as above: exactly 2 transfers, (5,3,010) then (159,119,111), then done.

Source files
------------

// File: rtl/fb_pkg.sv
// -----------------------------------------------------------------------------
// fb_pkg
// Shared definitions for the framebuffer plot sink / raster reader:
//   - default framebuffer geometry and pixel count
//   - address and coordinate widths
//   - colour type and controller state encoding
//   - pix_addr(): linear address of (x, y), y*width + x, at full address width
// Optional feature macro used by this slice: FB_NONZERO_ONLY_EN (see
// fb_plot_reader.sv).
// -----------------------------------------------------------------------------
package fb_pkg;

    localparam int FB_W_DEFAULT = 160;
    localparam int FB_H_DEFAULT = 120;
    localparam int FB_PIXELS    = FB_W_DEFAULT * FB_H_DEFAULT;

    localparam int ADDR_W = 15;
    localparam int X_W    = 8;
    localparam int Y_W    = 7;

    typedef logic [2:0] colour_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CLEAR = 2'd1,
        ST_DUMP  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    // Both operands are widened before the multiply so the product is never
    // truncated to the coordinate width.
    function automatic logic [ADDR_W-1:0] pix_addr(
        input logic [X_W-1:0] x,
        input logic [Y_W-1:0] y,
        input int             width
    );
        return ADDR_W'(y) * ADDR_W'(width) + ADDR_W'(x);
    endfunction

endpackage

// File: rtl/fb_ram.sv
// -----------------------------------------------------------------------------
// fb_ram
// Inferred simple dual-port (1 write, 1 read) synchronous RAM holding one
// colour per pixel. Read data is registered (1-cycle latency) and only updates
// when re is high, so the read register doubles as a stallable pipeline stage.
// A read and a write to the same address on the same edge returns the old
// contents. Contents have no reset.
// Ports:
//   clk           clock
//   we/waddr/wdata write port
//   re/raddr      read request (address sampled when re=1)
//   rdata         registered read data
// -----------------------------------------------------------------------------
module fb_ram
    import fb_pkg::*;
#(
    parameter int DEPTH = FB_PIXELS
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  colour_t           wdata,
    input  logic              re,
    input  logic [ADDR_W-1:0] raddr,
    output colour_t           rdata
);

    colour_t mem [DEPTH];
    colour_t rdata_q;

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        if (re) begin
            rdata_q <= mem[raddr];
        end
    end

    assign rdata = rdata_q;

endmodule

// File: rtl/fb_plot_reader.sv
// -----------------------------------------------------------------------------
// fb_plot_reader
// Sink for the vga_x/vga_y/vga_colour/vga_plot pixel-writer interface. Keeps a
// FB_W x FB_H x 3-bit framebuffer in block RAM, can clear it to CLEAR_COLOUR,
// and streams it back in raster order (x fastest) over a valid/ready port.
//
// Ports:
//   clk, rst_n              clock, asynchronous active-low reset
//   vga_x/vga_y/vga_colour  plot coordinate and colour
//   vga_plot                write strobe, one pixel per cycle
//   start_clear/start_dump  operation requests (clear wins if both high)
//   done                    operation finished, held until both starts low
//   out_x/out_y/out_colour  presented pixel
//   out_valid/out_ready     stream handshake
//
// Optional build macro FB_NONZERO_ONLY_EN: when defined, the dump skips
// pixels whose colour is 0 (they are read but never presented).
//
// Read pipeline: read counter -> RAM read register (prefetch stage, with its
// coordinates in pf_*) -> output register. Both stages advance independently
// so a full pipeline streams one pixel per cycle with out_ready high.
// -----------------------------------------------------------------------------
module fb_plot_reader
    import fb_pkg::*;
#(
    parameter int      FB_W         = FB_W_DEFAULT,
    parameter int      FB_H         = FB_H_DEFAULT,
    parameter colour_t CLEAR_COLOUR = 3'b000
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [X_W-1:0] vga_x,
    input  logic [Y_W-1:0] vga_y,
    input  colour_t        vga_colour,
    input  logic           vga_plot,
    input  logic           start_clear,
    input  logic           start_dump,
    output logic           done,
    output logic [X_W-1:0] out_x,
    output logic [Y_W-1:0] out_y,
    output colour_t        out_colour,
    output logic           out_valid,
    input  logic           out_ready
);

    localparam int                PIXELS    = FB_W * FB_H;
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(PIXELS - 1);
    localparam logic [X_W-1:0]    LAST_X    = X_W'(FB_W - 1);
    localparam logic [X_W:0]      X_LIMIT   = (X_W + 1)'(FB_W);
    localparam logic [Y_W:0]      Y_LIMIT   = (Y_W + 1)'(FB_H);

    // ---------------------------------------------------------------- state
    state_t state_q, state_d;

    // Registered plot request; the RAM write happens one edge after capture.
    logic              plot_pend_q,   plot_pend_d;
    logic [ADDR_W-1:0] plot_addr_q,   plot_addr_d;
    colour_t           plot_colour_q, plot_colour_d;

    logic [ADDR_W-1:0] clr_addr_q, clr_addr_d;

    // Read-address counter with matching coordinates (avoids a divider).
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic [X_W-1:0]    rd_x_q,    rd_x_d;
    logic [Y_W-1:0]    rd_y_q,    rd_y_d;
    logic              rd_all_q,  rd_all_d;   // every address has been issued

    // Prefetch stage: coordinates of the pixel sitting in the RAM read register.
    logic              pf_valid_q, pf_valid_d;
    logic [X_W-1:0]    pf_x_q,     pf_x_d;
    logic [Y_W-1:0]    pf_y_q,     pf_y_d;

    logic              out_valid_q,  out_valid_d;
    logic [X_W-1:0]    out_x_q,      out_x_d;
    logic [Y_W-1:0]    out_y_q,      out_y_d;
    colour_t           out_colour_q, out_colour_d;
    logic              done_q,       done_d;

    // ---------------------------------------------------------------- RAM
    logic              ram_we;
    logic [ADDR_W-1:0] ram_waddr;
    colour_t           ram_wdata;
    logic              ram_re;
    colour_t           ram_rdata;

    fb_ram #(
        .DEPTH (PIXELS)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (ram_waddr),
        .wdata (ram_wdata),
        .re    (ram_re),
        .raddr (rd_addr_q),
        .rdata (ram_rdata)
    );

    // ------------------------------------------------------ pipeline control
    logic pf_present;   // prefetch stage holds a pixel that must be presented
    logic out_adv;      // output register may load this cycle
    logic pf_adv;       // prefetch stage may load this cycle
    logic issue;        // a RAM read is launched this cycle
    logic dump_drained; // after this edge nothing is left to present
    logic clear_last;   // this edge writes the final clear address
    logic plot_in_range;

    always_comb begin
        pf_present = pf_valid_q;
`ifdef FB_NONZERO_ONLY_EN
        // A zero pixel is dropped right out of the prefetch stage, which frees
        // the stage so the scan keeps moving at one address per cycle.
        pf_present = pf_valid_q && (ram_rdata != 3'b000);
`endif
        out_adv       = !out_valid_q || out_ready;
        pf_adv        = !pf_present || out_adv;
        issue         = (state_q == ST_DUMP) && !rd_all_q && pf_adv;
        dump_drained  = rd_all_q && !pf_present && out_adv;
        clear_last    = (clr_addr_q == LAST_ADDR);
        plot_in_range = ({1'b0, vga_x} < X_LIMIT) && ({1'b0, vga_y} < Y_LIMIT);
    end

    // ------------------------------------------------------- state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------- next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE: begin
                if (start_clear) begin
                    state_d = ST_CLEAR;
                end else if (start_dump) begin
                    state_d = ST_DUMP;
                end
            end
            ST_CLEAR: begin
                if (clear_last) begin
                    state_d = ST_DONE;
                end
            end
            ST_DUMP: begin
                if (dump_drained) begin
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                // Only a fully released request returns to IDLE, so a start
                // that is still held cannot start a second operation.
                if (!start_clear && !start_dump) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // ------------------------------------------------ datapath / output logic
    always_comb begin
        // Plot capture: accepted everywhere except during a clear.
        plot_pend_d   = vga_plot && plot_in_range && (state_q != ST_CLEAR);
        plot_addr_d   = pix_addr(vga_x, vga_y, FB_W);
        plot_colour_d = vga_colour;

        // RAM write port: the clear sweep owns it while clearing; a plot
        // captured on the entry edge would be overwritten by the sweep anyway.
        if (state_q == ST_CLEAR) begin
            ram_we    = 1'b1;
            ram_waddr = clr_addr_q;
            ram_wdata = CLEAR_COLOUR;
        end else begin
            ram_we    = plot_pend_q;
            ram_waddr = plot_addr_q;
            ram_wdata = plot_colour_q;
        end
        ram_re = issue;

        clr_addr_d = (state_q == ST_CLEAR) ? clr_addr_q + ADDR_W'(1) : '0;

        // Read counter
        rd_addr_d = rd_addr_q;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        rd_all_d  = rd_all_q;
        if (state_q != ST_DUMP) begin
            rd_addr_d = '0;
            rd_x_d    = '0;
            rd_y_d    = '0;
            rd_all_d  = 1'b0;
        end else if (issue) begin
            if (rd_addr_q == LAST_ADDR) begin
                rd_all_d = 1'b1;
            end else begin
                rd_addr_d = rd_addr_q + ADDR_W'(1);
                if (rd_x_q == LAST_X) begin
                    rd_x_d = '0;
                    rd_y_d = rd_y_q + Y_W'(1);
                end else begin
                    rd_x_d = rd_x_q + X_W'(1);
                end
            end
        end

        // Prefetch stage tracks what the RAM read register holds.
        pf_valid_d = pf_valid_q;
        pf_x_d     = pf_x_q;
        pf_y_d     = pf_y_q;
        if (state_q != ST_DUMP) begin
            pf_valid_d = 1'b0;
        end else if (pf_adv) begin
            pf_valid_d = issue;
            pf_x_d     = rd_x_q;
            pf_y_d     = rd_y_q;
        end

        // Output register: holds steady while stalled.
        out_valid_d  = out_valid_q;
        out_x_d      = out_x_q;
        out_y_d      = out_y_q;
        out_colour_d = out_colour_q;
        if (state_q != ST_DUMP) begin
            out_valid_d = 1'b0;
        end else if (out_adv) begin
            out_valid_d = pf_present;
            if (pf_present) begin
                out_x_d      = pf_x_q;
                out_y_d      = pf_y_q;
                out_colour_d = ram_rdata;
            end
        end

        done_d = (state_d == ST_DONE);
    end

    // ------------------------------------------------------- datapath flops
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            plot_pend_q   <= 1'b0;
            plot_addr_q   <= '0;
            plot_colour_q <= '0;
            clr_addr_q    <= '0;
            rd_addr_q     <= '0;
            rd_x_q        <= '0;
            rd_y_q        <= '0;
            rd_all_q      <= 1'b0;
            pf_valid_q    <= 1'b0;
            pf_x_q        <= '0;
            pf_y_q        <= '0;
            out_valid_q   <= 1'b0;
            out_x_q       <= '0;
            out_y_q       <= '0;
            out_colour_q  <= '0;
            done_q        <= 1'b0;
        end else begin
            plot_pend_q   <= plot_pend_d;
            plot_addr_q   <= plot_addr_d;
            plot_colour_q <= plot_colour_d;
            clr_addr_q    <= clr_addr_d;
            rd_addr_q     <= rd_addr_d;
            rd_x_q        <= rd_x_d;
            rd_y_q        <= rd_y_d;
            rd_all_q      <= rd_all_d;
            pf_valid_q    <= pf_valid_d;
            pf_x_q        <= pf_x_d;
            pf_y_q        <= pf_y_d;
            out_valid_q   <= out_valid_d;
            out_x_q       <= out_x_d;
            out_y_q       <= out_y_d;
            out_colour_q  <= out_colour_d;
            done_q        <= done_d;
        end
    end

    assign done       = done_q;
    assign out_valid  = out_valid_q;
    assign out_x      = out_x_q;
    assign out_y      = out_y_q;
    assign out_colour = out_colour_q;

endmodule

// File: tb/tb_fb_plot_reader.sv
`timescale 1ns/1ps
// Directed bench for fb_plot_reader: clear, plots, dumps with and without
// backpressure, and reset in the middle of a dump. A bench-side framebuffer
// model gives the expected raster stream.
module tb_fb_plot_reader;

    localparam int W = 160;
    localparam int H = 120;
    localparam int N = W * H;
    localparam int DUMP_BOUND = 60000;

`ifdef FB_NONZERO_ONLY_EN
    localparam bit SKIP_ZERO = 1'b1;
`else
    localparam bit SKIP_ZERO = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] vga_x = '0;
    logic [6:0] vga_y = '0;
    logic [2:0] vga_colour = '0;
    logic       vga_plot = 1'b0;
    logic       start_clear = 1'b0;
    logic       start_dump = 1'b0;
    logic       out_ready = 1'b0;
    logic       done;
    logic [7:0] out_x;
    logic [6:0] out_y;
    logic [2:0] out_colour;
    logic       out_valid;

    int checks = 0;
    int errors = 0;

    logic [2:0] exp_fb      [N];
    logic [2:0] got_by_addr [N];

    always #5 clk = ~clk;

    fb_plot_reader dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_x       (vga_x),
        .vga_y       (vga_y),
        .vga_colour  (vga_colour),
        .vga_plot    (vga_plot),
        .start_clear (start_clear),
        .start_dump  (start_dump),
        .done        (done),
        .out_x       (out_x),
        .out_y       (out_y),
        .out_colour  (out_colour),
        .out_valid   (out_valid),
        .out_ready   (out_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    // One plot strobe; called at a negedge, returns at the next negedge.
    task automatic plot(input int x, input int y, input logic [2:0] c);
        vga_x      = 8'(x);
        vga_y      = 7'(y);
        vga_colour = c;
        vga_plot   = 1'b1;
        @(negedge clk);
        vga_plot   = 1'b0;
        if (x < W && y < H) exp_fb[y * W + x] = c;
        $display("plot   x=%0d y=%0d colour=%0d", x, y, c);
    endtask

    // Runs a dump from IDLE. abort_at>0 stops right after deciding that
    // transfer (used to reset mid-stream).
    task automatic run_dump(input string tag, input bit stall, input int abort_at);
        int q[$];
        int xfers = 0, bad = 0, gaps = 0, unstable = 0, lat = -1, cyc = 0, k;
        int lx = -1, ly = -1, ex_lx, ex_ly;
        bit hold = 1'b0, finished = 1'b0, aborted = 1'b0;
        logic [7:0] hx = '0;
        logic [6:0] hy = '0;
        logic [2:0] hc = '0;

        for (int i = 0; i < N; i++) begin
            got_by_addr[i] = 'x;
            if (!SKIP_ZERO || exp_fb[i] != 3'd0) q.push_back(i);
        end

        start_dump = 1'b1;
        out_ready  = 1'b1;
        @(negedge clk);           // start_dump sampled on the edge just passed
        start_dump = 1'b0;

        while (!finished && !aborted && cyc < DUMP_BOUND) begin
            if (out_valid === 1'b1) begin
                if (lat < 0) lat = cyc;
                if (hold && (out_x !== hx || out_y !== hy || out_colour !== hc)) unstable++;
            end else begin
                if (hold) unstable++;
                if (lat >= 0 && !stall && xfers < q.size()) gaps++;
            end
            if (done === 1'b1) begin
                finished = 1'b1;
            end else begin
                out_ready = stall ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (out_valid === 1'b1 && out_ready) begin
                    hold = 1'b0;
                    if (xfers < q.size()) begin
                        k = q[xfers];
                        if (32'(out_x) !== 32'(k % W) || 32'(out_y) !== 32'(k / W) ||
                            out_colour !== exp_fb[k]) bad++;
                    end else begin
                        bad++;
                    end
                    if (int'(out_x) < W && int'(out_y) < H)
                        got_by_addr[int'(out_y) * W + int'(out_x)] = out_colour;
                    lx = int'(out_x);
                    ly = int'(out_y);
                    xfers++;
                    if (xfers == abort_at) aborted = 1'b1;
                end else if (out_valid === 1'b1) begin
                    hold = 1'b1;
                    hx = out_x;
                    hy = out_y;
                    hc = out_colour;
                end else begin
                    hold = 1'b0;
                end
                if (!aborted) begin
                    @(negedge clk);
                    cyc++;
                end
            end
        end

        check({tag, "_first_latency"}, 32'(lat), (q.size() > 0) ? 32'(q[0] + 2) : 32'hFFFF_FFFF);
        check({tag, "_bad_pixels"}, 32'(bad), 32'd0);
        if (!aborted) begin
            ex_lx = (q.size() > 0) ? q[q.size() - 1] % W : -1;
            ex_ly = (q.size() > 0) ? q[q.size() - 1] / W : -1;
            check({tag, "_done_reached"}, 32'(finished), 32'd1);
            check({tag, "_transfers"}, 32'(xfers), 32'(q.size()));
            check({tag, "_gaps"}, 32'(gaps), 32'd0);
            check({tag, "_stall_unstable"}, 32'(unstable), 32'd0);
            check({tag, "_out_valid_at_done"}, 32'(out_valid), 32'd0);
            check({tag, "_last_x"}, 32'(lx), 32'(ex_lx));
            check({tag, "_last_y"}, 32'(ly), 32'(ex_ly));
            @(negedge clk);
            check({tag, "_done_released"}, 32'(done), 32'd0);
        end
        $display("dump   %s transfers=%0d expected=%0d latency=%0d cycles=%0d", tag, xfers, q.size(), lat, cyc);
    endtask

    initial begin
        int n;

        // ---- reset state
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_done", 32'(done), 32'd0);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_out_x", 32'(out_x), 32'd0);
        check("reset_out_y", 32'(out_y), 32'd0);
        check("reset_out_colour", 32'(out_colour), 32'd0);
        $display("reset  outputs checked");
        rst_n = 1'b1;
        @(negedge clk);

        // ---- clear with start_clear held high until after done
        start_clear = 1'b1;
        @(negedge clk);
        n = 0;
        while (done !== 1'b1 && n < 25000) begin
            @(negedge clk);
            n++;
        end
        check("clear_cycles_to_done", 32'(n), 32'd19200);
        repeat (3) @(negedge clk);
        check("clear_held_start_no_retrigger", 32'(done), 32'd1);
        start_clear = 1'b0;
        @(negedge clk);
        check("clear_done_released", 32'(done), 32'd0);
        for (int i = 0; i < N; i++) exp_fb[i] = 3'd0;
        $display("clear  done after %0d cycles", n);

        // ---- dump of cleared buffer
        run_dump("dump_clear", 1'b0, 0);

        // ---- two in-range plots, then dump
        plot(5, 3, 3'b010);
        plot(159, 119, 3'b111);
        @(negedge clk);
        run_dump("dump_plots", 1'b0, 0);
        check("dump_plots_addr485", 32'(got_by_addr[485]), 32'd2);
        check("dump_plots_addr19199", 32'(got_by_addr[19199]), 32'd7);

        // ---- out-of-range plots are dropped; dump under backpressure
        plot(160, 0, 3'b111);
        plot(0, 120, 3'b111);
        @(negedge clk);
        run_dump("dump_stall", 1'b1, 0);

        // ---- reset in the middle of a dump
        run_dump("dump_abort", 1'b0, 1000);
        rst_n = 1'b0;
        #1;
        check("midreset_out_valid", 32'(out_valid), 32'd0);
        check("midreset_done", 32'(done), 32'd0);
        $display("reset  asserted mid-dump");
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        run_dump("dump_restart", 1'b0, 1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
